dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous-read data memory between a load unit and a store unit
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ld_req_valid/ready, ld_addr,   load request handshake, address and destination tag
//   ld_tag
//   st_req_valid/ready, st_addr,   store request handshake, address and data
//   st_data
//   flush                          kills in-flight loads and blocks new loads
//   ld_resp_valid/data/tag         load response, one cycle per load, no backpressure
//   mem_addr/wdata/wr, mem_rdata   registered memory port; read data arrives one cycle after the address
module dmem_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_req_valid,
  output logic       ld_req_ready,
  input  logic [7:0] ld_addr,
  input  logic [2:0] ld_tag,
  input  logic       st_req_valid,
  output logic       st_req_ready,
  input  logic [7:0] st_addr,
  input  logic [7:0] st_data,
  input  logic       flush,
  output logic       ld_resp_valid,
  output logic [7:0] ld_resp_data,
  output logic [2:0] ld_resp_tag,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wr,
  input  logic [7:0] mem_rdata
);
  localparam logic GNT_LD = 1'b0;
  localparam logic GNT_ST = 1'b1;
  logic       last_q, last_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       mem_wr_q, mem_wr_d;
  logic       s1_vld_q, s1_vld_d;
  logic [2:0] s1_tag_q, s1_tag_d;
  logic       s2_vld_q, s2_vld_d;
  logic [2:0] s2_tag_q, s2_tag_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [2:0] rsp_tag_q, rsp_tag_d;
  logic       ld_live, same_addr, ld_acc, st_acc, s2_live;
  // Each ready is built straight from the valids so neither depends on the other.
  // A matching address forces the store first so the load sees the new data.
  always_comb begin
    ld_live      = ld_req_valid & ~flush;
    same_addr    = ld_addr == st_addr;
    st_req_ready = st_req_valid & (~ld_live | same_addr | (last_q == GNT_LD));
    ld_req_ready = ld_live & (~st_req_valid | (~same_addr & (last_q == GNT_ST)));
    ld_acc       = ld_req_valid & ld_req_ready;
    st_acc       = st_req_valid & st_req_ready;
    s2_live      = s2_vld_q & ~flush;
    last_d       = st_acc ? GNT_ST : ld_acc ? GNT_LD : last_q;
    mem_addr_d   = st_acc ? st_addr : ld_acc ? ld_addr : mem_addr_q;
    mem_wdata_d  = st_acc ? st_data : mem_wdata_q;
    mem_wr_d     = st_acc;
    s1_vld_d     = ld_acc;
    s1_tag_d     = ld_acc ? ld_tag : s1_tag_q;
    s2_vld_d     = s1_vld_q & ~flush;
    s2_tag_d     = s1_tag_q;
    rsp_vld_d    = s2_live;
    rsp_data_d   = s2_live ? mem_rdata : rsp_data_q;
    rsp_tag_d    = s2_live ? s2_tag_q : rsp_tag_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= GNT_ST;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_tag_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_tag_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      s1_vld_q    <= s1_vld_d;
      s1_tag_q    <= s1_tag_d;
      s2_vld_q    <= s2_vld_d;
      s2_tag_q    <= s2_tag_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wr        = mem_wr_q;
  assign ld_resp_valid = rsp_vld_q;
  assign ld_resp_data  = rsp_data_q;
  assign ld_resp_tag   = rsp_tag_q;
endmodule
